// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, flag bit positions and response record
package alu_pkg;
  localparam int ALU_LAT_DEFAULT = 2;
  localparam int TAG_W_DEFAULT = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;
  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7
  } alu_op_e;
  typedef struct packed {
    logic [15:0]              result;
    logic [3:0]               flags;
    logic [TAG_W_DEFAULT-1:0] tag;
  } alu_rsp_t;
endpackage

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: first-word-fall-through response FIFO with occupancy count
module alu_rsp_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type T = alu_rsp_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  T                           din,
  input  logic                       pop,
  output logic                       valid,
  output T                           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  T mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign valid = count != '0;
  assign do_pop = pop && valid;
  assign dout = valid ? mem[rd_ptr] : '0;
  // storage write, no reset needed since reads are gated by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
  // pointers wrap modulo DEPTH; count tracked separately
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end
  no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !do_pop && count == CW'(DEPTH)));
endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: issues tagged ops to the ALU and returns results in order
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int ALU_LAT = ALU_LAT_DEFAULT,
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  input  logic [3:0]       req_opcode,
  input  logic             req_cin,
  input  logic             req_chain,
  input  logic [TAG_W-1:0] req_tag,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [3:0]       alu_opcode,
  output logic             alu_cin,
  output logic             alu_en,
  input  logic [15:0]      alu_result,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);
  typedef struct packed {
    logic [15:0]      result;
    logic [3:0]       flags;
    logic [TAG_W-1:0] tag;
  } rsp_t;
  localparam int OW = $clog2(RSP_DEPTH + ALU_LAT + 1);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  logic [ALU_LAT-1:0] pipe_v;
  logic [TAG_W-1:0] pipe_tag [ALU_LAT];
  logic carry_q, issue, push;
  logic [OW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  rsp_t push_data, head;
  // count ops currently travelling through the ALU pipeline
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ALU_LAT; i++) inflight = inflight + OW'(pipe_v[i]);
  end
  // chained ops wait for an empty pipe so carry_q reflects the previous op
  assign req_ready = !RST && (inflight + OW'(fifo_count) < OW'(RSP_DEPTH)) && !(req_chain && inflight != '0);
  assign issue = req_valid && req_ready;
  assign alu_en = issue;
  assign alu_a = req_a;
  assign alu_b = req_b;
  assign alu_opcode = req_opcode;
  assign alu_cin = req_chain ? carry_q : req_cin;
  assign push = pipe_v[ALU_LAT-1];
  assign push_data = '{result: alu_result, flags: alu_flags, tag: pipe_tag[ALU_LAT-1]};
  // valid pipe and carry capture; both discarded on reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      pipe_v  <= '0;
      carry_q <= 1'b0;
    end else begin
      pipe_v <= ALU_LAT'({pipe_v, issue});
      if (push) carry_q <= alu_flags[FLAG_C];
    end
  end
  // tags ride alongside the valid bits; qualified by pipe_v so no reset
  always_ff @(posedge CLK) begin
    for (int i = ALU_LAT - 1; i > 0; i--) pipe_tag[i] <= pipe_tag[i-1];
    pipe_tag[0] <= req_tag;
  end
  alu_rsp_fifo #(.DEPTH(RSP_DEPTH), .T(rsp_t)) u_fifo (
    .clk  (CLK),
    .rst  (RST),
    .push (push),
    .din  (push_data),
    .pop  (rsp_ready),
    .valid(rsp_valid),
    .dout (head),
    .count(fifo_count)
  );
  assign rsp_result = head.result;
  assign rsp_flags = head.flags;
  assign rsp_tag = head.tag;
  assign busy = |pipe_v || fifo_count != '0;
endmodule
